// File: rtl/watch_defs.sv
// watch_defs: shared field limits, widths and controller state encodings for the watch chip
package watch_defs;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;
  localparam int CS_MAX   = 99;
  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int CS_W     = 7;
  typedef enum logic [2:0] {
    ST_TIME     = 3'd0,
    ST_SET_MIN  = 3'd1,
    ST_SET_HOUR = 3'd2,
    ST_SW_STOP  = 3'd3,
    ST_SW_RUN   = 3'd4
  } ctrl_state_e;
endpackage

// File: rtl/watch_mod_counter.sv
// watch_mod_counter: modulo-(MAX+1) up/down counter with wrap carry
//   clk, reset_n (sync, active-low), en_inc / en_dec (both at once = hold),
//   clr (sync clear), value (registered), carry (combinational, high when an inc wraps)
module watch_mod_counter #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_inc,
  input  logic             en_dec,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
  logic up, dn;
  always_comb begin
    up    = en_inc && !en_dec;
    dn    = en_dec && !en_inc;
    carry = !clr && up && value == TOP;
  end
  always_ff @(posedge clk) begin
    if (!reset_n || clr) value <= '0;
    else if (up) value <= value == TOP ? '0 : value + 1'b1;
    else if (dn) value <= value == '0 ? TOP : value - 1'b1;
  end
endmodule

// File: rtl/watch_timekeeper.sv
// watch_timekeeper: time-of-day and stopwatch counting core
//   clk, reset_n (sync, active-low); run_time, inc_m, dec_m, inc_h, dec_h (set buttons);
//   run_stopwatch, reset_stopwatch; outputs hours/minutes/seconds, sw_min/sw_sec/sw_cs,
//   sw_overflow (sticky) and tick_1hz (one-cycle pulse per second rollover)
module watch_timekeeper
  import watch_defs::*;
#(
  parameter int SEC_DIV = 32768,
  parameter int SW_DIV  = 328
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run_time,
  input  logic              inc_m,
  input  logic              dec_m,
  input  logic              inc_h,
  input  logic              dec_h,
  input  logic              run_stopwatch,
  input  logic              reset_stopwatch,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  sw_min,
  output logic [SEC_W-1:0]  sw_sec,
  output logic [CS_W-1:0]   sw_cs,
  output logic              sw_overflow,
  output logic              tick_1hz
);
  localparam int TPW = $clog2(SEC_DIV);
  localparam int SPW = $clog2(SW_DIV);
  logic [TPW-1:0] t_psc;
  logic [SPW-1:0] s_psc;
  // button history and rising edges, ordered {inc_m, dec_m, inc_h, dec_h}
  logic [3:0] hist, btn, rise;
  logic tick, sw_step, sec_carry, min_carry, unused_hr_carry, cs_carry, ss_carry, sm_carry;
  always_comb begin
    btn     = {inc_m, dec_m, inc_h, dec_h};
    rise    = run_time ? 4'b0 : btn & ~hist;
    tick    = run_time && t_psc == TPW'(SEC_DIV - 1);
    sw_step = run_stopwatch && s_psc == SPW'(SW_DIV - 1);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      t_psc       <= '0;
      s_psc       <= '0;
      hist        <= '1;
      tick_1hz    <= 1'b0;
      sw_overflow <= 1'b0;
    end else begin
      hist     <= btn;
      tick_1hz <= tick;
      t_psc    <= !run_time || tick ? '0 : t_psc + 1'b1;
      if (reset_stopwatch) begin
        s_psc       <= '0;
        sw_overflow <= 1'b0;
      end else begin
        // a paused prescaler keeps its phase so resume continues mid-centisecond
        if (run_stopwatch) s_psc <= sw_step ? '0 : s_psc + 1'b1;
        sw_overflow <= sw_overflow | sm_carry;
      end
    end
  end
  watch_mod_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk(clk), .reset_n(reset_n), .en_inc(tick), .en_dec(1'b0), .clr(!run_time),
    .value(seconds), .carry(sec_carry)
  );
  watch_mod_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk(clk), .reset_n(reset_n), .en_inc(sec_carry | rise[3]), .en_dec(rise[2]), .clr(1'b0),
    .value(minutes), .carry(min_carry)
  );
  // a minute wrap from the set button must not reach the hours
  watch_mod_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hr (
    .clk(clk), .reset_n(reset_n), .en_inc((run_time & min_carry) | rise[1]), .en_dec(rise[0]),
    .clr(1'b0), .value(hours), .carry(unused_hr_carry)
  );
  watch_mod_counter #(.MAX(CS_MAX), .WIDTH(CS_W)) u_cs (
    .clk(clk), .reset_n(reset_n), .en_inc(sw_step), .en_dec(1'b0), .clr(reset_stopwatch),
    .value(sw_cs), .carry(cs_carry)
  );
  watch_mod_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_ss (
    .clk(clk), .reset_n(reset_n), .en_inc(cs_carry), .en_dec(1'b0), .clr(reset_stopwatch),
    .value(sw_sec), .carry(ss_carry)
  );
  watch_mod_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_sm (
    .clk(clk), .reset_n(reset_n), .en_inc(ss_carry), .en_dec(1'b0), .clr(reset_stopwatch),
    .value(sw_min), .carry(sm_carry)
  );
endmodule
